// File: rtl/bus_fabric.sv
// bus_fabric: address decoder for NREG memory-mapped regions, with a built-in
// byte-copy DMA engine. A CPU write to DMA_ADDR starts the copy. While the copy
// runs, the CPU may use only region SAFE_IDX.
module bus_fabric #(
  parameter int unsigned            AW          = 16,
  parameter int unsigned            DW          = 8,
  parameter int unsigned            NREG        = 4,
  parameter logic [NREG*AW-1:0]     REGION_VAL  = {16'hFF80, 16'hFE00, 16'hC000, 16'h0000},
  parameter logic [NREG*AW-1:0]     REGION_MASK = {16'hFF80, 16'hFF00, 16'hE000, 16'h8000},
  parameter int unsigned            SAFE_IDX    = NREG - 1,
  parameter logic [AW-1:0]          DMA_ADDR    = 16'hFF46,
  parameter logic [AW-1:0]          DMA_DST     = 16'hFE00,
  parameter int unsigned            DMA_LEN     = 160
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [AW-1:0]        cpu_addr,
  input  logic [DW-1:0]        cpu_dout,
  input  logic                 cpu_write,
  output logic [DW-1:0]        cpu_din,
  output logic [NREG*AW-1:0]   reg_addr,
  output logic [NREG*DW-1:0]   reg_wdata,
  output logic [NREG-1:0]      reg_write,
  input  logic [NREG*DW-1:0]   reg_rdata,
  output logic                 dma_busy
);

  localparam int unsigned IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR} state_t;

  state_t          state_q, state_d;
  logic [DW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   src_hi_q, src_hi_d;
  logic [DW-1:0]   buf_q, buf_d;

  logic            cpu_is_dma, cpu_hit, dma_hit, dma_ok, busy, cpu_ok;
  logic [IW-1:0]   cpu_idx, dma_idx;
  logic [AW-1:0]   dma_addr;
  logic [DW-1:0]   dma_rdata;

  // Lowest-index region whose masked address matches; returns {hit, index}.
  function automatic logic [IW:0] decode(input logic [AW-1:0] a);
    logic [IW:0] r;
    r = '0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (!r[IW] && ((a & REGION_MASK[i*AW +: AW]) == REGION_VAL[i*AW +: AW])) begin
        r = {1'b1, IW'(i)};
      end
    end
    return r;
  endfunction

  assign busy       = (state_q != S_IDLE);
  assign dma_busy   = busy;
  assign cpu_is_dma = (cpu_addr == DMA_ADDR);
  assign {cpu_hit, cpu_idx} = decode(cpu_addr);

  // DMA side: the source is {src_hi, idx} when reading; the destination wraps modulo 2**AW.
  assign dma_addr = (state_q == S_WR) ? AW'(DMA_DST + AW'(idx_q)) : {src_hi_q, idx_q};
  assign {dma_hit, dma_idx} = decode(dma_addr);
  assign dma_ok    = busy && dma_hit && (dma_idx != IW'(SAFE_IDX));
  assign dma_rdata = dma_ok ? reg_rdata[dma_idx*DW +: DW] : '1;

  // The CPU reaches a region when idle, or only region SAFE_IDX while a DMA is running.
  assign cpu_ok = !cpu_is_dma && cpu_hit && (!busy || (cpu_idx == IW'(SAFE_IDX)));

  // Route the CPU and DMA masters onto the region ports.
  always_comb begin
    reg_addr  = {NREG{cpu_addr}};
    reg_wdata = {NREG{cpu_dout}};
    reg_write = '0;
    cpu_din   = '1;
    if (cpu_is_dma) begin
      cpu_din = src_hi_q;
    end else if (cpu_ok) begin
      cpu_din            = reg_rdata[cpu_idx*DW +: DW];
      reg_write[cpu_idx] = cpu_write;
    end
    if (dma_ok) begin
      reg_addr[dma_idx*AW +: AW]  = dma_addr;
      reg_wdata[dma_idx*DW +: DW] = buf_q;
      reg_write[dma_idx]          = (state_q == S_WR);
    end
  end

  // DMA sequencing: alternate RD and WR for DMA_LEN bytes. A trigger restarts the copy from any state.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    src_hi_d = src_hi_q;
    buf_d    = buf_q;
    case (state_q)
      S_RD: begin
        buf_d   = dma_rdata;
        state_d = S_WR;
      end
      S_WR: begin
        idx_d   = DW'(idx_q + 1'b1);
        state_d = (idx_q == DW'(DMA_LEN - 1)) ? S_IDLE : S_RD;
      end
      default: ;
    endcase
    if (cpu_write && cpu_is_dma) begin
      src_hi_d = cpu_dout;
      idx_d    = '0;
      state_d  = S_RD;
    end
  end

  // State registers; reset cancels any transfer in progress.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      idx_q    <= '0;
      src_hi_q <= '0;
      buf_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      src_hi_q <= src_hi_d;
      buf_q    <= buf_d;
    end
  end

endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed vectors for bus_fabric, using the default region map:
//   r0 0x0000/0x8000 (rdata = addr[7:0]^0x3C)
//   r1 0xC000/0xE000 (rdata = addr[7:0] + (addr[12] ? 0x40 : 0))
//   r2 0xFE00/0xFF00 (DMA destination, logged)
//   r3 0xFF80/0xFF80 (128-byte RAM)
module tb_bus_fabric;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned NREG = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic [AW-1:0]       cpu_addr;
  logic [DW-1:0]       cpu_dout;
  logic                cpu_write;
  logic [DW-1:0]       cpu_din;
  logic [NREG*AW-1:0]  reg_addr;
  logic [NREG*DW-1:0]  reg_wdata;
  logic [NREG-1:0]     reg_write;
  logic [NREG*DW-1:0]  reg_rdata;
  logic                dma_busy;

  int n_vec = 0;
  int n_bad = 0;

  logic [7:0] mem3 [128];
  logic [7:0] dst  [256];
  int wr_cnt = 0;
  int dst_bad_hi = 0;
  int busy_cnt = 0;
  int r0_wr_cnt = 0;

  bus_fabric dut (
    .clk       (clk),
    .rst       (rst),
    .cpu_addr  (cpu_addr),
    .cpu_dout  (cpu_dout),
    .cpu_write (cpu_write),
    .cpu_din   (cpu_din),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_write (reg_write),
    .reg_rdata (reg_rdata),
    .dma_busy  (dma_busy)
  );

  always #5 clk = ~clk;

  // Region read models.
  always_comb begin
    reg_rdata[7:0]   = reg_addr[7:0] ^ 8'h3C;
    reg_rdata[15:8]  = reg_addr[23:16] + (reg_addr[28] ? 8'h40 : 8'h00);
    reg_rdata[23:16] = dst[reg_addr[39:32]];
    reg_rdata[31:24] = mem3[reg_addr[54:48]];
  end

  // Region write models and activity counters.
  always @(posedge clk) begin
    if (dma_busy) busy_cnt++;
    if (reg_write[0]) r0_wr_cnt++;
    if (reg_write[2]) begin
      wr_cnt++;
      dst[reg_addr[39:32]] <= reg_wdata[23:16];
      if (reg_addr[47:40] != 8'hFE) dst_bad_hi++;
    end
    if (reg_write[3]) mem3[reg_addr[54:48]] <= reg_wdata[31:24];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cpu_rd(input string tag, input logic [AW-1:0] a, input logic [DW-1:0] exp);
    cpu_addr  = a;
    cpu_write = 1'b0;
    #1;
    check(tag, 32'(cpu_din), 32'(exp));
  endtask

  task automatic cpu_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cpu_addr  = a;
    cpu_dout  = d;
    cpu_write = 1'b1;
    @(posedge clk);
    #1;
    cpu_write = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (!dma_busy) break;
    end
    check("idle_timeout", 32'(dma_busy), 32'd0);
  endtask

  task automatic wait_wr(input int n);
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      if (wr_cnt >= n) break;
    end
    check("wr_wait", wr_cnt, n);
  endtask

  // Watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0_before;
    for (int i = 0; i < 128; i++) mem3[i] = 8'h00;
    for (int i = 0; i < 256; i++) dst[i] = 8'h00;
    rst = 1'b1;
    cpu_addr = '0;
    cpu_dout = '0;
    cpu_write = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(dma_busy), 32'd0);
    cpu_rd("rst_src_hi", 16'hFF46, 8'h00);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Idle decode.
    cpu_rd("rd_r0_1234", 16'h1234, 8'h08);
    cpu_rd("rd_r1_c005", 16'hC005, 8'h05);
    cpu_rd("rd_unmatched", 16'hA000, 8'hFF);
    cpu_addr = 16'hA000; cpu_write = 1'b1; #1;
    check("wr_unmatched_strobe", 32'(reg_write), 32'd0);
    cpu_write = 1'b0;
    cpu_wr(16'hFF90, 8'h77);
    cpu_rd("rd_r3_ff90", 16'hFF90, 8'h77);

    // Full DMA from 0xC000, with CPU traffic to regions 3 and 0 in the middle.
    cpu_addr = 16'hFF46; cpu_dout = 8'hC0; cpu_write = 1'b1; #1;
    check("trig_not_fwd", 32'(reg_write), 32'd0);
    busy_cnt = 0;
    wr_cnt = 0;
    @(posedge clk);
    #1;
    cpu_write = 1'b0;
    check("busy_rise", 32'(dma_busy), 32'd1);
    repeat (20) @(posedge clk);
    #1;
    cpu_wr(16'hFF85, 8'h5A);
    cpu_rd("dma_rd_r3", 16'hFF85, 8'h5A);
    cpu_rd("dma_rd_r0_blocked", 16'h1000, 8'hFF);
    cpu_rd("dma_rd_src_hi", 16'hFF46, 8'hC0);
    r0_before = r0_wr_cnt;
    cpu_addr = 16'h1000; cpu_dout = 8'h11; cpu_write = 1'b1; #1;
    check("dma_r0_strobe", 32'(reg_write[0]), 32'd0);
    @(posedge clk);
    #1;
    cpu_write = 1'b0;
    check("dma_r0_no_write", r0_wr_cnt, r0_before);
    wait_idle();
    check("dma_busy_cycles", busy_cnt, 320);
    check("dma_wr_count", wr_cnt, 160);
    check("dma_dst_hi", dst_bad_hi, 0);
    for (int k = 0; k < 160; k++) check($sformatf("dst_%0d", k), 32'(dst[k]), k);
    check("dst_160_untouched", 32'(dst[160]), 32'd0);
    check("mem3_5a", 32'(mem3[5]), 32'h5A);
    cpu_rd("post_src_hi", 16'hFF46, 8'hC0);

    // Retrigger at idx 50 with 0xD0: region 1 then returns k+0x40.
    busy_cnt = 0;
    wr_cnt = 0;
    cpu_wr(16'hFF46, 8'hC0);
    wait_wr(50);
    check("retrig_busy_pre", busy_cnt, 100);
    cpu_wr(16'hFF46, 8'hD0);
    busy_cnt = 0;
    wait_idle();
    check("retrig_busy_post", busy_cnt, 320);
    check("retrig_wr_count", wr_cnt, 210);
    check("retrig_dst0", 32'(dst[0]), 32'h40);
    check("retrig_dst50", 32'(dst[50]), 32'h72);
    check("retrig_dst159", 32'(dst[159]), 32'hDF);
    cpu_rd("retrig_src_hi", 16'hFF46, 8'hD0);

    // Reset in the middle of a transfer.
    wr_cnt = 0;
    cpu_wr(16'hFF46, 8'hC0);
    wait_wr(10);
    rst = 1'b1;
    #1;
    check("rst_async_busy", 32'(dma_busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("rst_no_resume_busy", 32'(dma_busy), 32'd0);
    check("rst_no_more_wr", wr_cnt, 10);
    cpu_rd("rst_src_hi_cleared", 16'hFF46, 8'h00);
    cpu_rd("rst_idle_r0", 16'h0042, 8'h7E);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
